// File: rtl/memory_pipe.sv
// MEM/WB pipeline stage: issues and holds the data-memory request until dhit,
// steers byte/half/word lanes with sign-extension, and registers writeback fields.
module memory_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int NPC_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [1:0]        size,
  input  logic              lsigned,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] storedata,
  input  logic [NPC_W-1:0]  nPC,
  input  logic              regWr,
  input  logic [1:0]        regSel,
  input  logic [REG_W-1:0]  regDst,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W/8-1:0] dmembyteen,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              mem_stall,
  output logic              out_valid,
  output logic [NPC_W-1:0]  nPC_next,
  output logic              regWr_next,
  output logic [1:0]        regSel_next,
  output logic [REG_W-1:0]  regDst_next,
  output logic [ADDR_W-1:0] ALUOut_next,
  output logic [DATA_W-1:0] dmemload_next,
  output logic              misalign
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam logic [LANES-1:0] BE_BYTE = LANES'(4'h1);
  localparam logic [LANES-1:0] BE_HALF = LANES'(4'h3);
  localparam logic [LANES-1:0] BE_WORD = LANES'(4'hF);
  localparam logic [OFF_W-1:0] WORD_OFF_MASK = ~OFF_W'(3);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic              flushed_q, ren_q, wen_q, outValid_q, regWr_q, misalign_q;
  logic [ADDR_W-1:0] addr_q, alu_q;
  logic [DATA_W-1:0] store_q, load_q;
  logic [LANES-1:0]  be_q;
  logic [NPC_W-1:0]  nPC_q;
  logic [1:0]        regSel_q;
  logic [REG_W-1:0]  regDst_q;

  logic [NPC_W-1:0]  shNPC_q;
  logic              shRegWr_q, shSigned_q, shStore_q;
  logic [1:0]        shRegSel_q, shSize_q;
  logic [REG_W-1:0]  shRegDst_q;
  logic [ADDR_W-1:0] shAlu_q;
  logic [OFF_W-1:0]  shOff_q;

  logic [OFF_W-1:0]  offset;
  logic              isMem, misaligned, accept;
  logic [DATA_W-1:0] storeData, shifted, loadMask, loadExt;
  logic [LANES-1:0]  storeBe;
  logic              loadMsb;

  assign offset = ALUOut[OFF_W-1:0];

  always_comb begin
    isMem      = dREN | dWEN;
    misaligned = (size == 2'b01 && offset[0]) || (size[1] && offset[1:0] != 2'b00);
    accept     = (state_q == S_IDLE) && !flush && en && in_valid && isMem && !misaligned;
  end

  // Store operand is replicated across the bus so any lane the enables pick is correct.
  always_comb begin
    storeData = '0;
    storeBe   = '0;
    case (size)
      2'b00: begin
        storeData = {LANES{storedata[7:0]}};
        storeBe   = BE_BYTE << offset;
      end
      2'b01: begin
        storeData = {(LANES/2){storedata[15:0]}};
        storeBe   = BE_HALF << offset;
      end
      default: begin
        storeData = {(DATA_W/32){storedata[31:0]}};
        storeBe   = BE_WORD << (offset & WORD_OFF_MASK);
      end
    endcase
  end

  always_comb begin
    shifted  = dmemload >> {shOff_q, 3'b000};
    loadMask = DATA_W'(32'hFFFF_FFFF);
    loadMsb  = shifted[31];
    case (shSize_q)
      2'b00: begin
        loadMask = DATA_W'(8'hFF);
        loadMsb  = shifted[7];
      end
      2'b01: begin
        loadMask = DATA_W'(16'hFFFF);
        loadMsb  = shifted[15];
      end
      default: ;
    endcase
    loadExt = (shifted & loadMask) | ({DATA_W{shSigned_q & loadMsb}} & ~loadMask);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_WAIT;
      S_WAIT:  if (dhit)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = (state_q == S_WAIT);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flushed_q  <= 1'b0;  ren_q      <= 1'b0;  wen_q    <= 1'b0;
      addr_q     <= '0;    store_q    <= '0;    be_q     <= '0;
      outValid_q <= 1'b0;  nPC_q      <= '0;    regWr_q  <= 1'b0;
      regSel_q   <= '0;    regDst_q   <= '0;    alu_q    <= '0;
      load_q     <= '0;    misalign_q <= 1'b0;
      shNPC_q    <= '0;    shRegWr_q  <= 1'b0;  shRegSel_q <= '0;
      shRegDst_q <= '0;    shAlu_q    <= '0;    shSize_q   <= '0;
      shOff_q    <= '0;    shSigned_q <= 1'b0;  shStore_q  <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (flush || (en && !in_valid)) begin
        outValid_q <= 1'b0;
        regWr_q    <= 1'b0;
      end else if (en && isMem && misaligned) begin
        outValid_q <= 1'b1;
        misalign_q <= 1'b1;
        regWr_q    <= 1'b0;
        nPC_q      <= nPC;
        regSel_q   <= regSel;
        regDst_q   <= regDst;
        alu_q      <= ALUOut;
        load_q     <= '0;
      end else if (accept) begin
        ren_q      <= dREN & ~dWEN;
        wen_q      <= dWEN;
        addr_q     <= {ALUOut[ADDR_W-1:OFF_W], OFF_W'(0)};
        store_q    <= storeData;
        be_q       <= storeBe;
        outValid_q <= 1'b0;
        shNPC_q    <= nPC;
        shRegWr_q  <= regWr;
        shRegSel_q <= regSel;
        shRegDst_q <= regDst;
        shAlu_q    <= ALUOut;
        shSize_q   <= size;
        shOff_q    <= offset;
        shSigned_q <= lsigned;
        shStore_q  <= dWEN;
      end else if (en) begin
        outValid_q <= 1'b1;
        misalign_q <= 1'b0;
        nPC_q      <= nPC;
        regWr_q    <= regWr;
        regSel_q   <= regSel;
        regDst_q   <= regDst;
        alu_q      <= ALUOut;
        load_q     <= '0;
      end
    end else begin
      // The bus transaction always completes; a flush only discards its result.
      if (flush) flushed_q <= 1'b1;
      if (dhit) begin
        ren_q     <= 1'b0;
        wen_q     <= 1'b0;
        flushed_q <= 1'b0;
        if (flushed_q || flush) begin
          outValid_q <= 1'b0;
          regWr_q    <= 1'b0;
        end else begin
          outValid_q <= 1'b1;
          misalign_q <= 1'b0;
          nPC_q      <= shNPC_q;
          regWr_q    <= shRegWr_q;
          regSel_q   <= shRegSel_q;
          regDst_q   <= shRegDst_q;
          alu_q      <= shAlu_q;
          load_q     <= shStore_q ? '0 : loadExt;
        end
      end
    end
  end

  assign dmemREN       = ren_q;
  assign dmemWEN       = wen_q;
  assign dmemaddr      = addr_q;
  assign dmemstore     = store_q;
  assign dmembyteen    = be_q;
  assign out_valid     = outValid_q;
  assign nPC_next      = nPC_q;
  assign regWr_next    = regWr_q;
  assign regSel_next   = regSel_q;
  assign regDst_next   = regDst_q;
  assign ALUOut_next   = alu_q;
  assign dmemload_next = load_q;
  assign misalign      = misalign_q;
endmodule

// File: doc/memory_pipe.md
Name: memory_pipe

Overview:
Parametrised MEM/WB pipeline stage, successor to the single-cycle MEM latch. It owns the data-memory request: it issues a request, holds it until dhit and stalls the pipeline meanwhile. It also handles byte, halfword and word loads/stores with lane steering and sign-extension, and detects misalignment. Its registered outputs feed writeback.

Parameters:
DATA_W, 32, data bus width; multiple of 32; LANES = DATA_W/8
ADDR_W, 32, memory address width
REG_W, 5, register-index width
NPC_W, 32, next-PC width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
en  in  1  pipeline advance enable from hazard unit
flush  in  1  synchronous squash
in_valid  in  1  EX/MEM slot holds a real instruction
dREN  in  1  load
dWEN  in  1  store
size  in  2  00 byte, 01 half, 10 word; 11 treated as word
lsigned  in  1  sign-extend sub-word loads
ALUOut  in  ADDR_W  address or ALU result
storedata  in  DATA_W  store operand, low-aligned
nPC, regWr, regSel(2), regDst(REG_W)  in  —  writeback control, passed through
dmemREN, dmemWEN  out  1  memory request, registered
dmemaddr  out  ADDR_W  request address, low log2(LANES) bits zeroed
dmemstore  out  DATA_W  store data, replicated into the addressed lane
dmembyteen  out  LANES  byte enables
dhit  in  1  memory completion, one cycle
dmemload  in  DATA_W  raw load data, valid with dhit
mem_stall  out  1  combinational: state==WAIT
out_valid, nPC_next, regWr_next, regSel_next, regDst_next, ALUOut_next  out  —  WB registers
dmemload_next  out  DATA_W  extracted, extended load data
misalign  out  1  registered with out_valid

Behaviour:
- Reset (async): all outputs 0; state IDLE; flushed flag 0.
- IDLE, en=0 and flush=0: hold everything.
- IDLE, flush=1 (priority over en): out_valid<=0, regWr_next<=0; no request is issued.
- IDLE, en & in_valid & (dREN|dWEN), aligned: latch the request. Set dmemREN/dmemWEN the next edge, go to WAIT, out_valid<=0. The pass-through fields are captured in shadow registers.
- IDLE, en & in_valid & no memory op: WB registers <= inputs, out_valid<=1, misalign<=0. Latency 1 cycle.
- IDLE, en & !in_valid: out_valid<=0, regWr_next<=0.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. No request is issued. Result: out_valid<=1, misalign<=1, regWr_next<=0, other fields passed through.
- dREN & dWEN both set: treat as store.
- WAIT: the request is held stable; mem_stall=1; en is ignored.
  - flush in WAIT sets the flushed flag. The bus request still completes, because stores must not be torn.
  - On dhit: REN/WEN<=0 and state goes to IDLE. If flushed: out_valid<=0, regWr_next<=0. Otherwise: WB registers <= shadow, dmemload_next <= extracted load (0 for stores), out_valid<=1 for one cycle.
  - The flushed flag clears on exit from WAIT.
- dhit in IDLE is ignored.
- Lane o = addr[log2(LANES)-1:0].
  - Store byte: storedata[7:0] is replicated to every byte; byteen = 1<<o.
  - Store half: the low half is replicated; byteen = 2'b11<<o.
  - Store word: the low word is replicated; byteen = 4'hF<<(o&~3).
  - Load: select the same lane; zero- or sign-extend to DATA_W per lsigned.
- Reset mid-WAIT: the request drops immediately and the state returns to IDLE.
- Minimum memory-op latency: issue edge plus dhit cycle, so at least 2 cycles from acceptance to out_valid.

Test Plan:
- ALU op: ALUOut=0x1234, regWr=1, en=1 -> next cycle out_valid=1, ALUOut_next=0x1234, dmemREN=dmemWEN=0.
- Signed byte load: addr 0x103, dhit after 3 cycles with dmemload=0x80FFFFFF -> mem_stall=1 for 3 cycles, dmemaddr=0x100, byteen=4'b1000, dmemload_next=0xFFFFFF80, out_valid one cycle.
- Half store: addr 0x202, storedata=0xABCD -> dmemstore=0xABCDABCD, byteen=4'b1100, dmemWEN held until dhit, then 0.
- Misaligned: word load at 0x301 -> no dmemREN, out_valid=1, misalign=1, regWr_next=0.
- flush during WAIT on a store: WEN stays until dhit, then out_valid=0, regWr_next=0, state IDLE.
- nRST low mid-WAIT: all outputs 0 asynchronously; after release a new ALU op passes in 1 cycle.
